// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder and the pipe_mem stage:
// funct3 size codes, FSM encoding, opcodes and the latched request payload.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
  } req_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational RV64 lane logic: byte enables, store lane shift, load
// extract/extend, and misalign/illegal-funct3 detection.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  f3,
  input  logic [2:0]  addr_lo,
  input  logic        we,
  input  logic [63:0] wdata,
  input  logic [63:0] rdword,
  output logic [7:0]  be_c,
  output logic [63:0] wlane_c,
  output logic [63:0] rdata_c,
  output logic [3:0]  nbytes_c,
  output logic        misalign_c,
  output logic        illegal_c
);

  logic [5:0]  sh;
  logic [63:0] rsh;
  logic [7:0]  mask;

  always_comb begin
    sh         = {addr_lo, 3'b000};
    rsh        = rdword >> sh;
    wlane_c    = wdata << sh;
    mask       = 8'h01;
    nbytes_c   = 4'd1;
    misalign_c = 1'b0;
    rdata_c    = 64'd0;

    // f3[1:0] encodes log2 of the access size for both loads and stores
    case (f3[1:0])
      2'd1: begin mask = 8'h03; nbytes_c = 4'd2; misalign_c = addr_lo[0];      end
      2'd2: begin mask = 8'h0F; nbytes_c = 4'd4; misalign_c = |addr_lo[1:0];   end
      2'd3: begin mask = 8'hFF; nbytes_c = 4'd8; misalign_c = |addr_lo;        end
      default: ;
    endcase

    be_c      = mask << addr_lo;
    illegal_c = (f3 == 3'b111) || (we && f3[2]);

    case (f3)
      F3_B:    rdata_c = {{56{rsh[7]}},  rsh[7:0]};
      F3_H:    rdata_c = {{48{rsh[15]}}, rsh[15:0]};
      F3_W:    rdata_c = {{32{rsh[31]}}, rsh[31:0]};
      F3_D:    rdata_c = rsh;
      F3_BU:   rdata_c = {56'd0, rsh[7:0]};
      F3_HU:   rdata_c = {48'd0, rsh[15:0]};
      F3_WU:   rdata_c = {32'd0, rsh[31:0]};
      default: rdata_c = 64'd0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Byte-addressable little-endian data memory with programmable latency,
// valid/ready request and response channels, and error reporting.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 512,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_f3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam logic [63:0] BYTES = 64'(DEPTH) * 64'd8;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;
  req_t        req;
  logic [63:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [7:0]    be_c;
  logic [63:0]   wlane_c, ld_c;
  logic [3:0]    nbytes_c;
  logic          misalign_c, illegal_c, oor_c, err_c, accept_c, commit_c;

  lsu_align u_align (
    .f3         (req.f3),
    .addr_lo    (req.addr[2:0]),
    .we         (req.we),
    .wdata      (req.wdata),
    .rdword     (mem[idx]),
    .be_c       (be_c),
    .wlane_c    (wlane_c),
    .rdata_c    (ld_c),
    .nbytes_c   (nbytes_c),
    .misalign_c (misalign_c),
    .illegal_c  (illegal_c)
  );

  // Last byte of the access must stay below BYTES; compare avoids 64-bit wrap
  assign idx      = req.addr[AW+2:3];
  assign oor_c    = req.addr > (BYTES - 64'(nbytes_c));
  assign err_c    = illegal_c || misalign_c || oor_c;
  assign accept_c = req_valid && req_ready;
  assign commit_c = (state == BUSY) && (state_nxt == RESP);

  // Counter holds remaining BUSY cycles so rsp_valid rises LATENCY edges after accept
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept_c) begin
        state_nxt = BUSY;
        cnt_nxt   = 4'(LATENCY - 1);
      end
      BUSY: if (cnt == 4'd0) state_nxt = RESP;
            else cnt_nxt = cnt - 4'd1;
      RESP: if (rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      req       <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 64'd0;
      rsp_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      req_ready <= (state_nxt == IDLE);
      rsp_valid <= (state_nxt == RESP);
      if (accept_c) req <= '{we: req_we, f3: req_f3, addr: req_addr, wdata: req_wdata};
      if (commit_c) begin
        rsp_rdata <= (req.we || err_c) ? 64'd0 : ld_c;
        rsp_err   <= err_c;
      end
    end
  end

  // Storage has no reset; only clean stores commit, on the edge entering RESP
  always_ff @(posedge clk) begin
    if (commit_c && req.we && !err_c) begin
      for (int b = 0; b < 8; b++) begin
        if (be_c[b]) mem[idx][b*8 +: 8] <= wlane_c[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: sized stores/loads, extension,
// errors, backpressure and asynchronous reset behaviour.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int unsigned DEPTH   = 512;
  localparam int unsigned LATENCY = 2;
  localparam logic [63:0] TOP     = 64'(DEPTH) * 64'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_f3;
  logic [63:0] req_addr, req_wdata;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [63:0] rsp_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [64:0] sb_q [$];

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic        err;
  } vec_t;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_f3    (req_f3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Push the expectation, run one request/response handshake, report observations
  task automatic xact(input vec_t v, input int hold,
                      output logic [63:0] got_rdata, output logic got_err,
                      output int lat, output bit stable, output bit timeout);
    int w;
    sb_q.push_back({v.err, v.rdata});
    timeout = 1'b0;
    stable  = 1'b1;
    @(negedge clk);
    req_we = v.we; req_f3 = v.f3; req_addr = v.addr; req_wdata = v.wdata;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 50) begin @(negedge clk); w++; end
    if (!req_ready) timeout = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 50) begin @(posedge clk); #1; lat++; end
    if (!rsp_valid) timeout = 1'b1;
    got_rdata = rsp_rdata;
    got_err   = rsp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_rdata !== got_rdata || rsp_err !== got_err || req_ready !== 1'b0)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks += 4;
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got=%b want=1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
    if (rsp_rdata !== 64'd0) begin n_fail++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
    if (rsp_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_err got=%b want=0", rsp_err); end
  endtask

  task automatic test_init();
    vec_t v [5];
    logic [63:0] r; logic e; int lat; bit st, to; logic [64:0] exp;
    v[0] = '{1'b1, F3_D, 64'h00,      64'd0, 64'd0, 1'b0};
    v[1] = '{1'b1, F3_D, 64'h08,      64'd0, 64'd0, 1'b0};
    v[2] = '{1'b1, F3_D, 64'h20,      64'd0, 64'd0, 1'b0};
    v[3] = '{1'b1, F3_D, 64'h40,      64'd0, 64'd0, 1'b0};
    v[4] = '{1'b1, F3_D, TOP - 64'd8, 64'd0, 64'd0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      xact(v[i], 0, r, e, lat, st, to);
      exp = sb_q.pop_front();
      n_checks++;
      if (to || {e, r} !== exp) begin n_fail++; $display("FAIL init[%0d] got err=%b data=%h want err=%b data=%h", i, e, r, exp[64], exp[63:0]); end
    end
  endtask

  task automatic test_sd_ld();
    vec_t v [7];
    logic [63:0] r; logic e; int lat; bit st, to; logic [64:0] exp;
    v[0] = '{1'b1, F3_D,  64'h10, 64'hABCD_1234_5678_9ABC, 64'd0, 1'b0};
    v[1] = '{1'b0, F3_D,  64'h10, 64'd0, 64'hABCD_1234_5678_9ABC, 1'b0};
    v[2] = '{1'b1, F3_H,  64'h12, 64'h5555, 64'd0, 1'b0};
    v[3] = '{1'b0, F3_D,  64'h10, 64'd0, 64'hABCD_1234_5555_9ABC, 1'b0};
    v[4] = '{1'b0, F3_W,  64'h14, 64'd0, 64'hFFFF_FFFF_ABCD_1234, 1'b0};
    v[5] = '{1'b0, F3_WU, 64'h14, 64'd0, 64'h0000_0000_ABCD_1234, 1'b0};
    v[6] = '{1'b0, F3_B,  64'h10, 64'd0, 64'hFFFF_FFFF_FFFF_FFBC, 1'b0};
    for (int i = 0; i < 7; i++) begin
      xact(v[i], 0, r, e, lat, st, to);
      exp = sb_q.pop_front();
      n_checks += 2;
      if (to || {e, r} !== exp) begin n_fail++; $display("FAIL sd_ld[%0d] got err=%b data=%h want err=%b data=%h", i, e, r, exp[64], exp[63:0]); end
      if (lat != int'(LATENCY)) begin n_fail++; $display("FAIL sd_ld_latency[%0d] got=%0d want=%0d", i, lat, LATENCY); end
    end
  endtask

  task automatic test_extend();
    vec_t v [6];
    logic [63:0] r; logic e; int lat; bit st, to; logic [64:0] exp;
    v[0] = '{1'b1, F3_B,  64'h21, 64'h80, 64'd0, 1'b0};
    v[1] = '{1'b0, F3_B,  64'h21, 64'd0, 64'hFFFF_FFFF_FFFF_FF80, 1'b0};
    v[2] = '{1'b0, F3_BU, 64'h21, 64'd0, 64'h80, 1'b0};
    v[3] = '{1'b0, F3_D,  64'h20, 64'd0, 64'h8000, 1'b0};
    v[4] = '{1'b0, F3_H,  64'h20, 64'd0, 64'hFFFF_FFFF_FFFF_8000, 1'b0};
    v[5] = '{1'b0, F3_W,  64'h20, 64'd0, 64'h8000, 1'b0};
    for (int i = 0; i < 6; i++) begin
      xact(v[i], 0, r, e, lat, st, to);
      exp = sb_q.pop_front();
      n_checks++;
      if (to || {e, r} !== exp) begin n_fail++; $display("FAIL extend[%0d] got err=%b data=%h want err=%b data=%h", i, e, r, exp[64], exp[63:0]); end
    end
  endtask

  task automatic test_errors();
    vec_t v [14];
    logic [63:0] r; logic e; int lat; bit st, to; logic [64:0] exp;
    v[0]  = '{1'b1, F3_D,    64'h0F, 64'd11, 64'd0, 1'b1};
    v[1]  = '{1'b0, F3_D,    64'h08, 64'd0,  64'd0, 1'b0};
    v[2]  = '{1'b0, F3_W,    64'h02, 64'd0,  64'd0, 1'b1};
    v[3]  = '{1'b0, F3_H,    64'h21, 64'd0,  64'd0, 1'b1};
    v[4]  = '{1'b1, F3_W,    64'h12, 64'hFFFF_FFFF, 64'd0, 1'b1};
    v[5]  = '{1'b0, F3_D,    TOP,    64'd0,  64'd0, 1'b1};
    v[6]  = '{1'b0, F3_D,    TOP - 64'd8, 64'd0, 64'd0, 1'b0};
    v[7]  = '{1'b0, 3'b111,  64'h00, 64'd0,  64'd0, 1'b1};
    v[8]  = '{1'b1, F3_BU,   64'h00, 64'h7F, 64'd0, 1'b1};
    v[9]  = '{1'b1, F3_D,    TOP,    64'h1111, 64'd0, 1'b1};
    v[10] = '{1'b0, F3_D,    64'h00, 64'd0,  64'd0, 1'b0};
    v[11] = '{1'b0, F3_W,    TOP - 64'd4, 64'd0, 64'd0, 1'b0};
    v[12] = '{1'b0, F3_D,    64'hFFFF_FFFF_FFFF_FFF8, 64'd0, 64'd0, 1'b1};
    v[13] = '{1'b0, F3_H,    TOP - 64'd1, 64'd0, 64'd0, 1'b1};
    for (int i = 0; i < 14; i++) begin
      xact(v[i], 0, r, e, lat, st, to);
      exp = sb_q.pop_front();
      n_checks += 2;
      if (to || {e, r} !== exp) begin n_fail++; $display("FAIL errors[%0d] got err=%b data=%h want err=%b data=%h", i, e, r, exp[64], exp[63:0]); end
      if (lat != int'(LATENCY)) begin n_fail++; $display("FAIL errors_latency[%0d] got=%0d want=%0d", i, lat, LATENCY); end
    end
  endtask

  task automatic test_backpressure();
    vec_t v;
    logic [63:0] r; logic e; int lat; bit st, to; logic [64:0] exp;
    v = '{1'b0, F3_D, 64'h10, 64'd0, 64'hABCD_1234_5555_9ABC, 1'b0};
    xact(v, 5, r, e, lat, st, to);
    exp = sb_q.pop_front();
    n_checks += 3;
    if (to || {e, r} !== exp) begin n_fail++; $display("FAIL backpressure_data got err=%b data=%h want err=%b data=%h", e, r, exp[64], exp[63:0]); end
    if (st !== 1'b1) begin n_fail++; $display("FAIL backpressure_stable got=%b want=1", st); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL backpressure_req_ready got=%b want=1", req_ready); end
  endtask

  task automatic test_reset_busy();
    vec_t v;
    logic [63:0] r; logic e; int lat; bit st, to; logic [64:0] exp;
    @(negedge clk);
    req_we = 1'b1; req_f3 = F3_W; req_addr = 64'h40; req_wdata = 64'hDEAD_BEEF;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_checks += 2;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_busy_rsp_valid got=%b want=0", rsp_valid); end
    if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_busy_req_ready got=%b want=1", req_ready); end
    @(negedge clk);
    reset = 1'b0;
    v = '{1'b0, F3_W, 64'h40, 64'd0, 64'd0, 1'b0};
    xact(v, 0, r, e, lat, st, to);
    exp = sb_q.pop_front();
    n_checks++;
    if (to || {e, r} !== exp) begin n_fail++; $display("FAIL reset_busy_no_write got err=%b data=%h want err=%b data=%h", e, r, exp[64], exp[63:0]); end
  endtask

  task automatic test_reset_resp();
    int w;
    @(negedge clk);
    req_we = 1'b0; req_f3 = F3_D; req_addr = 64'h10; req_wdata = 64'd0;
    req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    w = 0;
    while (!rsp_valid && w < 50) begin @(posedge clk); #1; w++; end
    @(negedge clk);
    n_checks += 2;
    if (rsp_valid !== 1'b1) begin n_fail++; $display("FAIL reset_resp_pending got=%b want=1", rsp_valid); end
    reset = 1'b1;
    #1;
    if (rsp_valid !== 1'b0 || rsp_rdata !== 64'd0) begin
      n_fail++; $display("FAIL reset_resp_drop got valid=%b data=%h want valid=0 data=0", rsp_valid, rsp_rdata);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_f3 = 3'd0;
    req_addr = 64'd0; req_wdata = 64'd0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    test_init();
    test_sd_ld();
    test_extend();
    test_errors();
    test_backpressure();
    test_reset_busy();
    test_reset_resp();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
